writeback_stage: RTL and testbench

Final pipeline stage of the RISC-V core. It merges single-cycle ALU results and variable-latency load results into one registered write port that drives the register file's `wen`/`rd`/`din`. It also keeps a per-register busy scoreboard that stalls decode on RAW and WAW hazards. The register file reads combinationally and writes on the clock edge, so no forwarding network is needed.

---
 rtl/writeback_if.sv | 45 ++++
 rtl/writeback_stage.sv | 110 +++++++++++
 tb/tb_writeback_stage.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_if.sv
// Bundle of decode-issue, ALU/load result handshakes and register-file write port
// seen by the writeback stage.
interface writeback_if #(
  parameter int XLEN = 32
);
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic [4:0]      issue_rs1;
  logic [4:0]      issue_rs2;
  logic            stall;

  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;

  logic            ld_valid;
  logic            ld_ready;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;

  logic            rf_wen;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_din;

  modport slave (
    input  issue_valid, issue_rd, issue_rs1, issue_rs2,
    output stall,
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    input  ld_valid, ld_rd, ld_data,
    output ld_ready,
    output rf_wen, rf_rd, rf_din
  );

  modport master (
    output issue_valid, issue_rd, issue_rs1, issue_rs2,
    input  stall,
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    output ld_valid, ld_rd, ld_data,
    input  ld_ready,
    input  rf_wen, rf_rd, rf_din
  );
endinterface

// File: rtl/writeback_stage.sv
// Writeback stage: arbitrates ALU and load results onto one registered register-file
// write port, holds a losing load for one entry, and tracks busy registers for decode.
module writeback_stage #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 2
) (
  input logic        clk,
  input logic        rst,
  writeback_if.slave wb
);

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  logic [31:0]     busy_q, busy_d;
  logic            hold_full_q, hold_full_d;
  logic [4:0]      hold_rd_q, hold_rd_d;
  logic [XLEN-1:0] hold_data_q, hold_data_d;
  logic [2:0]      starve_q, starve_d;
  logic            rf_wen_q, rf_wen_d;
  logic [4:0]      rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_din_q, rf_din_d;

  logic alu_hs;
  logic ld_hs;
  logic issue_go;
  logic hold_starved;

  assign hold_starved = hold_full_q & (starve_q == STARVE_LIM);
  assign wb.ld_ready  = ~hold_full_q & ~rst;
  assign wb.alu_ready = ~rst & ~hold_starved;
  assign wb.stall     = wb.issue_valid &
                        (busy_q[wb.issue_rs1] | busy_q[wb.issue_rs2] | busy_q[wb.issue_rd]);

  assign alu_hs   = wb.alu_valid & wb.alu_ready;
  assign ld_hs    = wb.ld_valid & wb.ld_ready;
  assign issue_go = wb.issue_valid & ~wb.stall & (wb.issue_rd != 5'd0);

  assign wb.rf_wen = rf_wen_q;
  assign wb.rf_rd  = rf_rd_q;
  assign wb.rf_din = rf_din_q;

  always_comb begin
    rf_wen_d    = 1'b0;
    rf_rd_d     = rf_rd_q;
    rf_din_d    = rf_din_q;
    hold_full_d = hold_full_q;
    hold_rd_d   = hold_rd_q;
    hold_data_d = hold_data_q;
    starve_d    = starve_q;
    busy_d      = busy_q;

    // Priority: ALU, then held load, then a direct load.
    if (alu_hs) begin
      rf_rd_d  = wb.alu_rd;
      rf_din_d = wb.alu_data;
      rf_wen_d = (wb.alu_rd != 5'd0);
      if (ld_hs) begin
        hold_full_d = 1'b1;
        hold_rd_d   = wb.ld_rd;
        hold_data_d = wb.ld_data;
      end
      if (hold_full_q && (starve_q < STARVE_LIM)) begin
        starve_d = starve_q + 3'd1;
      end
    end else if (hold_full_q) begin
      rf_rd_d     = hold_rd_q;
      rf_din_d    = hold_data_q;
      rf_wen_d    = (hold_rd_q != 5'd0);
      hold_full_d = 1'b0;
      starve_d    = 3'd0;
    end else if (ld_hs) begin
      rf_rd_d  = wb.ld_rd;
      rf_din_d = wb.ld_data;
      rf_wen_d = (wb.ld_rd != 5'd0);
    end

    // Clear on the register-file write edge; a same-edge issue re-sets the bit.
    if (rf_wen_q) begin
      busy_d[rf_rd_q] = 1'b0;
    end
    if (issue_go) begin
      busy_d[wb.issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= '0;
      hold_full_q <= 1'b0;
      starve_q    <= 3'd0;
      rf_wen_q    <= 1'b0;
      rf_rd_q     <= 5'd0;
      rf_din_q    <= '0;
    end else begin
      busy_q      <= busy_d;
      hold_full_q <= hold_full_d;
      starve_q    <= starve_d;
      rf_wen_q    <= rf_wen_d;
      rf_rd_q     <= rf_rd_d;
      rf_din_q    <= rf_din_d;
    end
  end

  always_ff @(posedge clk) begin
    hold_rd_q   <= hold_rd_d;
    hold_data_q <= hold_data_d;
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed scenarios plus randomized traffic checked
// against a queue-based behavioural model of the stage.
module tb_writeback_stage;

  localparam int XLEN       = 32;
  localparam int STARVE_MAX = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  writeback_if #(.XLEN(XLEN)) wb ();

  writeback_stage #(.XLEN(XLEN), .STARVE_MAX(STARVE_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } res_t;

  // Behavioural model state
  bit [31:0]       m_busy;
  res_t            m_hold[$];
  int              m_starve;
  logic            e_wen;
  logic [4:0]      e_rd;
  logic [XLEN-1:0] e_din;
  logic            m_stall, m_alu_ready, m_ld_ready;

  function automatic void model_comb();
    m_ld_ready  = !rst && (m_hold.size() == 0);
    m_alu_ready = !rst && !((m_hold.size() != 0) && (m_starve == STARVE_MAX));
    m_stall     = wb.issue_valid &&
                  (m_busy[wb.issue_rs1] || m_busy[wb.issue_rs2] || m_busy[wb.issue_rd]);
  endfunction

  function automatic void model_write(input logic [4:0] rd, input logic [XLEN-1:0] d);
    e_rd  = rd;
    e_din = d;
    e_wen = (rd != 5'd0);
  endfunction

  // Advance the model across one clock edge using the inputs presented this cycle.
  function automatic void model_step();
    bit [31:0] nb;
    bit        had_hold, alu_t, ld_t;
    res_t      r;
    model_comb();
    if (rst) begin
      m_busy   = '0;
      m_hold.delete();
      m_starve = 0;
      e_wen    = 1'b0;
      e_rd     = 5'd0;
      e_din    = '0;
      return;
    end
    nb = m_busy;
    if (e_wen) nb[e_rd] = 1'b0;
    if (wb.issue_valid && !m_stall && wb.issue_rd != 5'd0) nb[wb.issue_rd] = 1'b1;
    had_hold = (m_hold.size() != 0);
    alu_t    = wb.alu_valid && m_alu_ready;
    ld_t     = wb.ld_valid && m_ld_ready;
    if (alu_t) begin
      model_write(wb.alu_rd, wb.alu_data);
      if (had_hold) m_starve = m_starve + 1;
      if (ld_t) begin
        r.rd = wb.ld_rd;
        r.data = wb.ld_data;
        m_hold.push_back(r);
      end
    end else if (had_hold) begin
      r = m_hold.pop_front();
      model_write(r.rd, r.data);
      m_starve = 0;
    end else if (ld_t) begin
      model_write(wb.ld_rd, wb.ld_data);
    end else begin
      e_wen = 1'b0;
    end
    m_busy = nb;
  endfunction

  task automatic set_in(input logic iv, input logic [4:0] ird, input logic [4:0] irs1,
                        input logic [4:0] irs2, input logic av, input logic [4:0] ard,
                        input logic [XLEN-1:0] ad, input logic lv, input logic [4:0] lrd,
                        input logic [XLEN-1:0] ldd);
    wb.issue_valid = iv;
    wb.issue_rd    = ird;
    wb.issue_rs1   = irs1;
    wb.issue_rs2   = irs2;
    wb.alu_valid   = av;
    wb.alu_rd      = ard;
    wb.alu_data    = ad;
    wb.ld_valid    = lv;
    wb.ld_rd       = lrd;
    wb.ld_data     = ldd;
    #1;
    model_comb();
  endtask

  task automatic idle();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    n_checks++; if (wb.alu_ready !== 1'b0) $display("FAIL rst_alu_ready got %0b want 0", wb.alu_ready); else n_pass++;
    n_checks++; if (wb.ld_ready !== 1'b0) $display("FAIL rst_ld_ready got %0b want 0", wb.ld_ready); else n_pass++;
    step();
    step();
    n_checks++; if (wb.rf_wen !== 1'b0) $display("FAIL rst_rf_wen got %0b want 0", wb.rf_wen); else n_pass++;
    n_checks++; if (wb.rf_rd !== 5'd0) $display("FAIL rst_rf_rd got %0d want 0", wb.rf_rd); else n_pass++;
    n_checks++; if (wb.rf_din !== 32'd0) $display("FAIL rst_rf_din got %h want 0", wb.rf_din); else n_pass++;
    rst = 1'b0;
    idle();
    n_checks++; if (wb.ld_ready !== 1'b1) $display("FAIL post_rst_ld_ready got %0b want 1", wb.ld_ready); else n_pass++;
  endtask

  task automatic test_alu_write();
    set_in(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    n_checks++; if (wb.stall !== 1'b0) $display("FAIL alu_issue_stall got %0b want 0", wb.stall); else n_pass++;
    step();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, '0);
    n_checks++; if (wb.alu_ready !== 1'b1) $display("FAIL alu_ready got %0b want 1", wb.alu_ready); else n_pass++;
    step();
    n_checks++; if (wb.rf_wen !== 1'b1) $display("FAIL alu_wen got %0b want 1", wb.rf_wen); else n_pass++;
    n_checks++; if (wb.rf_rd !== 5'd5) $display("FAIL alu_rd got %0d want 5", wb.rf_rd); else n_pass++;
    n_checks++; if (wb.rf_din !== 32'h1234) $display("FAIL alu_din got %h want 00001234", wb.rf_din); else n_pass++;
    set_in(1'b1, 5'd0, 5'd5, 5'd0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    n_checks++; if (wb.stall !== 1'b1) $display("FAIL alu_busy_n1 got %0b want 1", wb.stall); else n_pass++;
    step();
    set_in(1'b1, 5'd0, 5'd5, 5'd0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    n_checks++; if (wb.stall !== 1'b0) $display("FAIL alu_busy_n2 got %0b want 0", wb.stall); else n_pass++;
    step();
  endtask

  task automatic test_raw_stall();
    set_in(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    step();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 5'd0, 5'd7, 5'd0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
      n_checks++; if (wb.stall !== 1'b1) $display("FAIL raw_stall_wait%0d got %0b want 1", i, wb.stall); else n_pass++;
      step();
    end
    set_in(1'b1, 5'd0, 5'd7, 5'd0, 1'b0, 5'd0, '0, 1'b1, 5'd7, 32'hCAFE_0007);
    n_checks++; if (wb.ld_ready !== 1'b1) $display("FAIL raw_ld_ready got %0b want 1", wb.ld_ready); else n_pass++;
    step();
    n_checks++; if (wb.rf_wen !== 1'b1 || wb.rf_rd !== 5'd7) $display("FAIL raw_ld_write got wen=%0b rd=%0d want wen=1 rd=7", wb.rf_wen, wb.rf_rd); else n_pass++;
    n_checks++; if (wb.rf_din !== 32'hCAFE_0007) $display("FAIL raw_ld_din got %h want cafe0007", wb.rf_din); else n_pass++;
    set_in(1'b1, 5'd0, 5'd7, 5'd0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    n_checks++; if (wb.stall !== 1'b1) $display("FAIL raw_stall_n1 got %0b want 1", wb.stall); else n_pass++;
    step();
    set_in(1'b1, 5'd0, 5'd7, 5'd0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    n_checks++; if (wb.stall !== 1'b0) $display("FAIL raw_stall_n2 got %0b want 0", wb.stall); else n_pass++;
    step();
  endtask

  task automatic test_conflict();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd3, 32'h3333, 1'b1, 5'd4, 32'h4444);
    n_checks++; if (wb.alu_ready !== 1'b1 || wb.ld_ready !== 1'b1) $display("FAIL conf_ready got alu=%0b ld=%0b want 1 1", wb.alu_ready, wb.ld_ready); else n_pass++;
    step();
    n_checks++; if (wb.rf_rd !== 5'd3 || wb.rf_din !== 32'h3333) $display("FAIL conf_first got rd=%0d din=%h want rd=3 din=00003333", wb.rf_rd, wb.rf_din); else n_pass++;
    idle();
    n_checks++; if (wb.ld_ready !== 1'b0) $display("FAIL conf_bubble got %0b want 0", wb.ld_ready); else n_pass++;
    step();
    n_checks++; if (wb.rf_wen !== 1'b1 || wb.rf_rd !== 5'd4 || wb.rf_din !== 32'h4444) $display("FAIL conf_held got wen=%0b rd=%0d din=%h want 1 4 00004444", wb.rf_wen, wb.rf_rd, wb.rf_din); else n_pass++;
    idle();
    n_checks++; if (wb.ld_ready !== 1'b1) $display("FAIL conf_ld_ready_back got %0b want 1", wb.ld_ready); else n_pass++;
    step();
  endtask

  task automatic test_starvation();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
    step();
    for (int i = 0; i < STARVE_MAX; i++) begin
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'(16 + i), 32'(16 + i), 1'b0, 5'd0, '0);
      n_checks++; if (wb.alu_ready !== 1'b1) $display("FAIL starve_win%0d got %0b want 1", i, wb.alu_ready); else n_pass++;
      step();
      n_checks++; if (wb.rf_rd !== 5'(16 + i)) $display("FAIL starve_win_rd%0d got %0d want %0d", i, wb.rf_rd, 16 + i); else n_pass++;
    end
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd20, 32'h20, 1'b0, 5'd0, '0);
    n_checks++; if (wb.alu_ready !== 1'b0) $display("FAIL starve_backpressure got %0b want 0", wb.alu_ready); else n_pass++;
    step();
    n_checks++; if (wb.rf_rd !== 5'd2 || wb.rf_din !== 32'h22) $display("FAIL starve_hold_write got rd=%0d din=%h want 2 00000022", wb.rf_rd, wb.rf_din); else n_pass++;
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd20, 32'h20, 1'b0, 5'd0, '0);
    n_checks++; if (wb.alu_ready !== 1'b1 || wb.ld_ready !== 1'b1) $display("FAIL starve_release got alu=%0b ld=%0b want 1 1", wb.alu_ready, wb.ld_ready); else n_pass++;
    step();
    // A fresh conflict must see the counter restarted from zero.
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd21, 32'h21, 1'b1, 5'd22, 32'h2222);
    step();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd23, 32'h23, 1'b0, 5'd0, '0);
    step();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd24, 32'h24, 1'b0, 5'd0, '0);
    n_checks++; if (wb.alu_ready !== 1'b1) $display("FAIL starve_cnt_cleared got %0b want 1", wb.alu_ready); else n_pass++;
    step();
    idle();
    step();
    n_checks++; if (wb.rf_rd !== 5'd22 || wb.rf_din !== 32'h2222) $display("FAIL starve_second_hold got rd=%0d din=%h want 22 00002222", wb.rf_rd, wb.rf_din); else n_pass++;
  endtask

  task automatic test_x0();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, '0);
    n_checks++; if (wb.alu_ready !== 1'b1) $display("FAIL x0_alu_ready got %0b want 1", wb.alu_ready); else n_pass++;
    step();
    n_checks++; if (wb.rf_wen !== 1'b0) $display("FAIL x0_wen got %0b want 0", wb.rf_wen); else n_pass++;
    set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    n_checks++; if (wb.stall !== 1'b0) $display("FAIL x0_stall_a got %0b want 0", wb.stall); else n_pass++;
    step();
    set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    n_checks++; if (wb.stall !== 1'b0) $display("FAIL x0_stall_b got %0b want 0", wb.stall); else n_pass++;
    step();
  endtask

  task automatic test_reset_mid();
    set_in(1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    step();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd11, 32'h11, 1'b1, 5'd12, 32'h12);
    step();
    rst = 1'b1;
    idle();
    n_checks++; if (wb.ld_ready !== 1'b0 || wb.alu_ready !== 1'b0) $display("FAIL mid_rst_ready got alu=%0b ld=%0b want 0 0", wb.alu_ready, wb.ld_ready); else n_pass++;
    step();
    rst = 1'b0;
    n_checks++; if (wb.rf_wen !== 1'b0) $display("FAIL mid_rst_wen got %0b want 0", wb.rf_wen); else n_pass++;
    set_in(1'b1, 5'd0, 5'd9, 5'd0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    n_checks++; if (wb.stall !== 1'b0) $display("FAIL mid_rst_busy got %0b want 0", wb.stall); else n_pass++;
    n_checks++; if (wb.ld_ready !== 1'b1) $display("FAIL mid_rst_hold got %0b want 1", wb.ld_ready); else n_pass++;
    step();
    n_checks++; if (wb.rf_wen !== 1'b0) $display("FAIL mid_rst_no_hold_write got %0b want 0", wb.rf_wen); else n_pass++;
  endtask

  task automatic test_random();
    logic lv;
    logic [4:0] lrd;
    logic [XLEN-1:0] ldd;
    lv = 1'b0;
    lrd = 5'd0;
    ldd = '0;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 79) == 0);
      // Loads tend to be held until accepted, as a real load unit would.
      if (!lv || m_ld_ready || $urandom_range(0, 7) == 0) begin
        lv  = ($urandom_range(0, 1) == 1);
        lrd = 5'($urandom_range(0, 7));
        ldd = $urandom;
      end
      set_in($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)),
             $urandom, lv, lrd, ldd);
      if (wb.stall !== m_stall || wb.alu_ready !== m_alu_ready || wb.ld_ready !== m_ld_ready) begin
        n_checks++;
        $display("FAIL rand_comb c%0d got stall=%0b alu_rdy=%0b ld_rdy=%0b want %0b %0b %0b",
                 c, wb.stall, wb.alu_ready, wb.ld_ready, m_stall, m_alu_ready, m_ld_ready);
      end else begin
        n_checks++;
        n_pass++;
      end
      step();
      n_checks++;
      if (wb.rf_wen !== e_wen || (e_wen && (wb.rf_rd !== e_rd || wb.rf_din !== e_din)))
        $display("FAIL rand_write c%0d got wen=%0b rd=%0d din=%h want wen=%0b rd=%0d din=%h",
                 c, wb.rf_wen, wb.rf_rd, wb.rf_din, e_wen, e_rd, e_din);
      else
        n_pass++;
    end
    rst = 1'b0;
  endtask

  initial begin
    m_busy   = '0;
    m_starve = 0;
    e_wen    = 1'b0;
    e_rd     = 5'd0;
    e_din    = '0;
    test_reset();
    test_alu_write();
    test_raw_stall();
    test_conflict();
    test_starvation();
    test_x0();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
